// File: rtl/stream_pack_pkg.sv
// Shared types and helpers for the stream width packer.
// The parity helper is only used when PACKER_PARITY_EN is defined.
package stream_pack_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_RATIO      = 4;

  typedef logic [$clog2(DEF_RATIO)-1:0] lane_cnt_t;
  typedef logic [DEF_RATIO-1:0]         keep_t;

  // Even parity of one lane, forced to 0 when the lane carries no data.
  function automatic logic lane_parity(input logic [DEF_DATA_WIDTH-1:0] data,
                                       input logic                      keep);
    return keep & (^data);
  endfunction

endpackage

// File: rtl/stream_width_packer.sv
// Packs RATIO narrow beats into one wide word, lane 0 first, with a
// per-lane keep mask. A beat flagged in_last closes the word early.
// Optional feature: define PACKER_PARITY_EN to add out_parity, a per-lane
// even-parity vector registered alongside out_data.
module stream_width_packer
  import stream_pack_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int RATIO      = DEF_RATIO
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [DATA_WIDTH-1:0]       in_data,
  input  logic                        in_valid,
  input  logic                        in_last,
  output logic                        in_ready,
  output logic [DATA_WIDTH*RATIO-1:0] out_data,
  output logic [RATIO-1:0]            out_keep,
  output logic                        out_last,
  output logic                        out_valid,
  input  logic                        out_ready
`ifdef PACKER_PARITY_EN
  ,
  output logic [RATIO-1:0]            out_parity
`endif
);

  localparam int CW = $clog2(RATIO);
  localparam logic [CW-1:0] LAST_LANE = CW'(RATIO - 1);

  typedef enum logic {ACCUM, HOLD} state_t;

  state_t                      state;
  logic [CW-1:0]               count;
  logic [DATA_WIDTH*RATIO-1:0] acc;
  logic [RATIO-1:0]            keep;
  logic [DATA_WIDTH*RATIO-1:0] acc_next;
  logic [RATIO-1:0]            keep_next;
  logic                        in_fire;
  logic                        complete;

  // Ready only depends on the output register being free or draining now.
  assign in_ready = !out_valid || out_ready;
  assign in_fire  = in_valid && in_ready;
  assign complete = in_fire && ((count == LAST_LANE) || in_last);

  // Accumulator contents as they would look with the current beat merged in.
  always_comb begin
    acc_next  = acc;
    keep_next = keep;
    for (int k = 0; k < RATIO; k++) begin
      if (count == CW'(k)) begin
        acc_next[k*DATA_WIDTH +: DATA_WIDTH] = in_data;
        keep_next[k]                         = 1'b1;
      end
    end
  end

  // Lane accumulation, word hand-off to the output register and output state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ACCUM;
      count     <= '0;
      acc       <= '0;
      keep      <= '0;
      out_data  <= '0;
      out_keep  <= '0;
      out_last  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      if (complete) begin
        out_data  <= acc_next;
        out_keep  <= keep_next;
        out_last  <= in_last;
        out_valid <= 1'b1;
        state     <= HOLD;
        count     <= '0;
        acc       <= '0;
        keep      <= '0;
      end else begin
        if (in_fire) begin
          acc   <= acc_next;
          keep  <= keep_next;
          count <= count + 1'b1;
        end
        if (state == HOLD && out_ready) begin
          out_valid <= 1'b0;
          state     <= ACCUM;
        end
      end
    end
  end

`ifdef PACKER_PARITY_EN
  logic [RATIO-1:0] parity_next;

  // Per-lane parity of the word being completed; empty lanes are already 0.
  always_comb begin
    parity_next = '0;
    for (int k = 0; k < RATIO; k++) begin
      parity_next[k] = lane_parity(acc_next[k*DATA_WIDTH +: DATA_WIDTH], keep_next[k]);
    end
  end

  // Parity is captured in the same cycle as out_data so the two stay aligned.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_parity <= '0;
    end else if (complete) begin
      out_parity <= parity_next;
    end
  end
`endif

endmodule

// File: tb/tb_stream_width_packer.sv
// Self-checking bench for stream_width_packer (DATA_WIDTH=8, RATIO=4).
// Per-cycle vectors from a table, plus hand sequences for reset and parity.
module tb_stream_width_packer;

  logic        clk;
  logic        reset;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_last;
  logic        in_ready;
  logic [31:0] out_data;
  logic [3:0]  out_keep;
  logic        out_last;
  logic        out_valid;
  logic        out_ready;
`ifdef PACKER_PARITY_EN
  logic [3:0]  out_parity;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0]  data;
    logic        valid;
    logic        last;
    logic        ordy;
    logic        exp_in_ready;
    logic        exp_valid;
    logic [31:0] exp_data;
    logic [3:0]  exp_keep;
    logic        exp_last;
  } vec_t;

  vec_t vecs[$];

  stream_width_packer #(.DATA_WIDTH(8), .RATIO(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_keep  (out_keep),
    .out_last  (out_last),
    .out_valid (out_valid),
    .out_ready (out_ready)
`ifdef PACKER_PARITY_EN
    ,
    .out_parity(out_parity)
`endif
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic addVec(input logic [7:0] d, input logic v, input logic l, input logic r,
                        input logic eir, input logic ev, input logic [31:0] ed,
                        input logic [3:0] ek, input logic el);
    vec_t t;
    t.data = d; t.valid = v; t.last = l; t.ordy = r;
    t.exp_in_ready = eir; t.exp_valid = ev; t.exp_data = ed;
    t.exp_keep = ek; t.exp_last = el;
    vecs.push_back(t);
  endtask

  // Drive one cycle of inputs at the falling edge, check ready before the
  // rising edge and the registered outputs just after it.
  task automatic applyStimulus(input int idx, input vec_t t);
    @(negedge clk);
    in_data   = t.data;
    in_valid  = t.valid;
    in_last   = t.last;
    out_ready = t.ordy;
    #1;
    checkOutput($sformatf("row%0d in_ready", idx), {31'b0, in_ready}, {31'b0, t.exp_in_ready});
    @(posedge clk);
    #1;
    checkOutput($sformatf("row%0d out_valid", idx), {31'b0, out_valid}, {31'b0, t.exp_valid});
    checkOutput($sformatf("row%0d out_data", idx), out_data, t.exp_data);
    checkOutput($sformatf("row%0d out_keep", idx), {28'b0, out_keep}, {28'b0, t.exp_keep});
    checkOutput($sformatf("row%0d out_last", idx), {31'b0, out_last}, {31'b0, t.exp_last});
  endtask

  task automatic driveBeat(input logic [7:0] d, input logic l);
    @(negedge clk);
    in_data   = d;
    in_valid  = 1'b1;
    in_last   = l;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset     = 1'b1;
    in_data   = 8'h00;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;

    // Reset held for two rising edges.
    @(posedge clk);
    @(posedge clk);
    #1;
    checkOutput("reset out_valid", {31'b0, out_valid}, 32'd0);
    checkOutput("reset out_data", out_data, 32'd0);
    checkOutput("reset out_keep", {28'b0, out_keep}, 32'd0);
    checkOutput("reset out_last", {31'b0, out_last}, 32'd0);
    checkOutput("reset in_ready", {31'b0, in_ready}, 32'd1);
`ifdef PACKER_PARITY_EN
    checkOutput("reset out_parity", {28'b0, out_parity}, 32'd0);
`endif
    @(negedge clk);
    reset = 1'b0;

    // Two beats of a word, then an asynchronous reset that must discard them.
    driveBeat(8'hBB, 1'b0);
    driveBeat(8'hCC, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    reset    = 1'b1;
    #1;
    checkOutput("midreset out_valid", {31'b0, out_valid}, 32'd0);
    checkOutput("midreset out_keep", {28'b0, out_keep}, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Fresh word after reset: no trace of BB/CC.
    addVec(8'hA1, 1, 0, 1, 1, 0, 32'h0, 4'h0, 0);
    addVec(8'hA2, 1, 0, 1, 1, 0, 32'h0, 4'h0, 0);
    addVec(8'hA3, 1, 0, 1, 1, 0, 32'h0, 4'h0, 0);
    addVec(8'hA4, 1, 0, 1, 1, 1, 32'hA4A3A2A1, 4'hF, 0);
    // Full word, out_valid pulses one cycle.
    addVec(8'h11, 1, 0, 1, 1, 0, 32'hA4A3A2A1, 4'hF, 0);
    addVec(8'h22, 1, 0, 1, 1, 0, 32'hA4A3A2A1, 4'hF, 0);
    addVec(8'h33, 1, 0, 1, 1, 0, 32'hA4A3A2A1, 4'hF, 0);
    addVec(8'h44, 1, 0, 1, 1, 1, 32'h44332211, 4'hF, 0);
    // Partial word closed by in_last, then a one-lane word replacing it.
    addVec(8'h55, 1, 0, 1, 1, 0, 32'h44332211, 4'hF, 0);
    addVec(8'h66, 1, 1, 1, 1, 1, 32'h00006655, 4'h3, 1);
    addVec(8'h77, 1, 1, 1, 1, 1, 32'h00000077, 4'h1, 1);
    addVec(8'h00, 0, 0, 1, 1, 0, 32'h00000077, 4'h1, 1);
    // Word completed under back-pressure, held 5 cycles, then accepted.
    addVec(8'h01, 1, 0, 0, 1, 0, 32'h00000077, 4'h1, 1);
    addVec(8'h02, 1, 0, 0, 1, 0, 32'h00000077, 4'h1, 1);
    addVec(8'h03, 1, 0, 0, 1, 0, 32'h00000077, 4'h1, 1);
    addVec(8'h04, 1, 0, 0, 1, 1, 32'h04030201, 4'hF, 0);
    for (int i = 0; i < 5; i++) addVec(8'hEE, 1, 1, 0, 0, 1, 32'h04030201, 4'hF, 0);
    addVec(8'h00, 0, 0, 1, 1, 0, 32'h04030201, 4'hF, 0);
    // Continuous 12-beat stream with one idle gap mid-word.
    addVec(8'h01, 1, 0, 1, 1, 0, 32'h04030201, 4'hF, 0);
    addVec(8'h02, 1, 0, 1, 1, 0, 32'h04030201, 4'hF, 0);
    addVec(8'hFF, 0, 1, 1, 1, 0, 32'h04030201, 4'hF, 0);
    addVec(8'h03, 1, 0, 1, 1, 0, 32'h04030201, 4'hF, 0);
    addVec(8'h04, 1, 0, 1, 1, 1, 32'h04030201, 4'hF, 0);
    addVec(8'h05, 1, 0, 1, 1, 0, 32'h04030201, 4'hF, 0);
    addVec(8'h06, 1, 0, 1, 1, 0, 32'h04030201, 4'hF, 0);
    addVec(8'h07, 1, 0, 1, 1, 0, 32'h04030201, 4'hF, 0);
    addVec(8'h08, 1, 0, 1, 1, 1, 32'h08070605, 4'hF, 0);
    addVec(8'h09, 1, 0, 1, 1, 0, 32'h08070605, 4'hF, 0);
    addVec(8'h0A, 1, 0, 1, 1, 0, 32'h08070605, 4'hF, 0);
    addVec(8'h0B, 1, 0, 1, 1, 0, 32'h08070605, 4'hF, 0);
    addVec(8'h0C, 1, 0, 1, 1, 1, 32'h0C0B0A09, 4'hF, 0);
    addVec(8'h00, 0, 0, 1, 1, 0, 32'h0C0B0A09, 4'hF, 0);

    foreach (vecs[i]) applyStimulus(i, vecs[i]);

`ifdef PACKER_PARITY_EN
    // Lanes 01,03,07 have parities 1,0,1; the empty lane reads 0.
    driveBeat(8'h01, 1'b0);
    driveBeat(8'h03, 1'b0);
    driveBeat(8'h07, 1'b1);
    checkOutput("parity out_valid", {31'b0, out_valid}, 32'd1);
    checkOutput("parity out_data", out_data, 32'h00070301);
    checkOutput("parity out_keep", {28'b0, out_keep}, 32'h7);
    checkOutput("parity out_parity", {28'b0, out_parity}, 32'h5);
`endif

    @(negedge clk);
    in_valid = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
